// File: rtl/fifo_512_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_512_reader_if
// Brief    : FIFO read port plus beat stream/status bundle for fifo_512_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_512_reader_if #(
  parameter int DATA  = 512,
  parameter int CHUNK = 32
) ();

  logic             fifo_empty;
  logic [DATA-1:0]  fifo_data;
  logic             fifo_rd_en;
  logic [CHUNK-1:0] chunk_out;
  logic             chunk_valid;
  logic             chunk_last;
  logic             chunk_ready;
  logic             busy;
  logic [15:0]      words_done;

  // The reader drives the read strobe and the beat stream.
  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  chunk_ready,
    output fifo_rd_en,
    output chunk_out,
    output chunk_valid,
    output chunk_last,
    output busy,
    output words_done
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output chunk_ready,
    input  fifo_rd_en,
    input  chunk_out,
    input  chunk_valid,
    input  chunk_last,
    input  busy,
    input  words_done
  );

endinterface
`default_nettype wire

// File: rtl/fifo_512_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_512_reader
// Brief    : Pops DATA-bit FIFO words and streams them as CHUNK-bit beats, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_512_reader #(
  parameter int DATA  = 512,
  parameter int CHUNK = 32
) (
  input  logic              clk,
  input  logic              rst,
  fifo_512_reader_if.master bus
);

  localparam int c_NBEATS = DATA / CHUNK;
  localparam int c_BEAT_W = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_NBEATS - 1);

  generate
    if ((DATA % CHUNK) != 0) begin : g_bad_ratio
      $error("fifo_512_reader: DATA must be an integer multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LOAD = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rd_en;
  logic                w_rd_en_nxt;
  logic                r_chunk_valid;
  logic                w_valid_nxt;
  logic [DATA-1:0]     r_shift;
  logic [DATA-1:0]     w_shift_nxt;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_BEAT_W-1:0] w_beat_nxt;
  logic [15:0]         r_words_done;
  logic [15:0]         w_words_nxt;
  logic                w_xfer;
  logic                w_last;

  assign w_xfer = r_chunk_valid && bus.chunk_ready;
  assign w_last = r_chunk_valid && (r_beat == c_LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rd_en       <= 1'b0;
      r_chunk_valid <= 1'b0;
      r_shift       <= '0;
      r_beat        <= '0;
      r_words_done  <= 16'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_rd_en       <= w_rd_en_nxt;
      r_chunk_valid <= w_valid_nxt;
      r_shift       <= w_shift_nxt;
      r_beat        <= w_beat_nxt;
      r_words_done  <= w_words_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en_nxt = 1'b0;
    w_valid_nxt = r_chunk_valid;
    w_shift_nxt = r_shift;
    w_beat_nxt  = r_beat;
    w_words_nxt = r_words_done;

    unique case (r_state)
      S_IDLE: begin
        if (!bus.fifo_empty) begin
          w_rd_en_nxt = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end

      // The FIFO samples the strobe on this edge; its data is valid afterwards.
      S_WAIT: begin
        w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_shift_nxt = bus.fifo_data;
        w_beat_nxt  = '0;
        w_valid_nxt = 1'b1;
        w_state_nxt = S_SEND;
      end

      S_SEND: begin
        if (w_xfer) begin
          if (w_last) begin
            w_words_nxt = r_words_done + 16'd1;
            w_valid_nxt = 1'b0;
            if (!bus.fifo_empty) begin
              w_rd_en_nxt = 1'b1;
              w_state_nxt = S_WAIT;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_shift_nxt = r_shift >> CHUNK;
            w_beat_nxt  = r_beat + c_BEAT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en  = r_rd_en;
  assign bus.chunk_out   = r_shift[CHUNK-1:0];
  assign bus.chunk_valid = r_chunk_valid;
  assign bus.chunk_last  = w_last;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.words_done  = r_words_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_512_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_512_reader
// Brief    : Directed self-checking bench for fifo_512_reader with a small FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_512_reader;

  localparam int c_DATA  = 512;
  localparam int c_CHUNK = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fifo_512_reader_if #(.DATA(c_DATA), .CHUNK(c_CHUNK)) bus ();

  fifo_512_reader #(.DATA(c_DATA), .CHUNK(c_CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the edge that samples the strobe.
  logic [c_DATA-1:0] mem [0:15];
  int                wr_ptr;
  int                rd_ptr;
  int                rd_empty_err;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);

  initial begin
    rd_ptr       = 0;
    rd_empty_err = 0;
    bus.fifo_data = '0;
  end

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        rd_empty_err++;
      end else begin
        bus.fifo_data <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [c_DATA-1:0] make_word(input logic [31:0] base);
    logic [c_DATA-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = base + 32'(i);
    return w;
  endfunction

  task automatic push_word(input logic [31:0] base);
    mem[wr_ptr] = make_word(base);
    wr_ptr      = wr_ptr + 1;
  endtask

  logic [31:0] bv [$];
  int          bt [$];
  logic        bl [$];
  int          rd_high;
  int          stab_err;
  int          first_t;

  // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
  task automatic stream(input int nexp, input int mode, input int max_cyc);
    int          t;
    logic        pv;
    logic        pr;
    logic        pl;
    logic [31:0] po;
    bv.delete(); bt.delete(); bl.delete();
    rd_high = 0; stab_err = 0; first_t = -1;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; po = '0; t = 0;
    while (bv.size() < nexp && t < max_cyc) begin
      @(negedge clk);
      t++;
      bus.chunk_ready = (mode == 0) ? 1'b1 : (((t - 1) % 3) == 0);
      if (bus.fifo_rd_en) rd_high++;
      if (pv && !pr && (!bus.chunk_valid || bus.chunk_out !== po || bus.chunk_last !== pl))
        stab_err++;
      if (bus.chunk_valid && first_t < 0) first_t = t;
      if (bus.chunk_valid && bus.chunk_ready) begin
        bv.push_back(bus.chunk_out);
        bt.push_back(t);
        bl.push_back(bus.chunk_last);
      end
      pv = bus.chunk_valid; pr = bus.chunk_ready; po = bus.chunk_out; pl = bus.chunk_last;
    end
    chk("stream_beats", 64'(bv.size()), 64'(nexp));
  endtask

  task automatic chk_word(input string tag, input int first, input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      if (first + i < bv.size()) begin
        chk({tag, "_val"}, 64'(bv[first+i]), 64'(base + 32'(i)));
        chk({tag, "_last"}, 64'(bl[first+i]), 64'(i == 15));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    n_checks = 0;
    n_errors = 0;
    wr_ptr   = 0;
    rst      = 1'b0;
    bus.chunk_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.chunk_valid), 64'd0);
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_out",   64'(bus.chunk_out), 64'd0);
    chk("rst_last",  64'(bus.chunk_last), 64'd0);
    chk("rst_words", 64'(bus.words_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word, chunk i = i.
    push_word(32'd0);
    stream(16, 0, 40);
    chk("single_latency", 64'(first_t), 64'd3);
    chk("single_rd_pulse", 64'(rd_high), 64'd1);
    chk_word("single", 0, 32'd0);
    if (bv.size() == 16) chk("single_consec", 64'(bt[15] - bt[0]), 64'd15);
    @(negedge clk);
    chk("single_words", 64'(bus.words_done), 64'd1);
    chk("single_busy",  64'(bus.busy), 64'd0);
    chk("single_valid", 64'(bus.chunk_valid), 64'd0);

    // Back-to-back: three queued words.
    push_word(32'h100); push_word(32'h200); push_word(32'h300);
    stream(48, 0, 120);
    chk("b2b_rd_pulses", 64'(rd_high), 64'd3);
    chk_word("b2b_w0", 0, 32'h100);
    chk_word("b2b_w1", 16, 32'h200);
    chk_word("b2b_w2", 32, 32'h300);
    if (bv.size() == 48) begin
      chk("b2b_gap1", 64'(bt[16] - bt[15] - 1), 64'd2);
      chk("b2b_gap2", 64'(bt[32] - bt[31] - 1), 64'd2);
    end
    @(negedge clk);
    chk("b2b_words", 64'(bus.words_done), 64'd4);
    chk("b2b_fifo_empty", 64'(bus.fifo_empty), 64'd1);
    chk("b2b_busy", 64'(bus.busy), 64'd0);

    // Backpressure with ready 1,0,0 repeating.
    push_word(32'd0);
    stream(16, 1, 200);
    chk("bp_stable", 64'(stab_err), 64'd0);
    chk_word("bp", 0, 32'd0);
    bus.chunk_ready = 1'b1;
    @(negedge clk);
    chk("bp_words", 64'(bus.words_done), 64'd5);

    // Reset mid-word after beat 5; the second queued word must stream next.
    push_word(32'h1000); push_word(32'h2000);
    stream(6, 0, 40);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.chunk_valid), 64'd0);
    chk("mid_rst_out",   64'(bus.chunk_out), 64'd0);
    chk("mid_rst_last",  64'(bus.chunk_last), 64'd0);
    chk("mid_rst_busy",  64'(bus.busy), 64'd0);
    chk("mid_rst_words", 64'(bus.words_done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stream(16, 0, 40);
    chk("post_rst_latency", 64'(first_t), 64'd3);
    chk_word("post_rst", 0, 32'h2000);
    @(negedge clk);
    chk("post_rst_words", 64'(bus.words_done), 64'd1);

    // Empty FIFO for 100 cycles.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en || bus.chunk_valid || bus.busy) bad++;
    end
    chk("empty_idle", 64'(bad), 64'd0);

    // words_done wrap from 0xFFFF.
    force dut.r_words_done = 16'hFFFF;
    @(negedge clk);
    release dut.r_words_done;
    @(negedge clk);
    chk("wrap_preload", 64'(bus.words_done), 64'hFFFF);
    push_word(32'h55);
    stream(16, 0, 40);
    chk_word("wrap", 0, 32'h55);
    @(negedge clk);
    chk("wrap_words", 64'(bus.words_done), 64'd0);

    chk("fifo_underflow", 64'(rd_empty_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_512_reader.md
FIFO_512_READER -- requirements
Module: fifo_512_reader

Interface
REQ-001 Parameter DATA, default 512, SHALL set the FIFO word width in bits.
REQ-002 Parameter CHUNK, default 32, SHALL set the output beat width; DATA SHALL be an integer multiple of CHUNK; NBEATS = DATA/CHUNK (16 by default).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 fifo_empty  input  1  SHALL carry the FIFO empty flag (FIFO Out_Busy).
REQ-007 fifo_data  input  DATA  SHALL carry the FIFO read data, valid the cycle after the edge that samples fifo_rd_en=1.
REQ-008 fifo_rd_en  output  1  SHALL be the registered FIFO read strobe.
REQ-009 chunk_out  output  CHUNK  SHALL carry the current beat.
REQ-010 chunk_valid  output  1  SHALL indicate that chunk_out holds a beat.
REQ-011 chunk_last  output  1  SHALL mark beat NBEATS-1 of a word; asserted only with chunk_valid.
REQ-012 chunk_ready  input  1  SHALL be the downstream acceptance signal.
REQ-013 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 words_done  output  16  SHALL count fully transferred words, wrapping 0xFFFF->0x0000.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, LOAD and SEND.
REQ-016 IDLE: on an edge with fifo_empty=0, set fifo_rd_en<=1 and go to WAIT; otherwise remain in IDLE.
REQ-017 WAIT: on the next edge, set fifo_rd_en<=0 and go to LOAD. fifo_rd_en SHALL be high for exactly one cycle per word.
REQ-018 LOAD: on the next edge, capture fifo_data into a DATA-bit shift register, set beat counter to 0 and chunk_valid<=1, and go to SEND.
REQ-019 Latency: chunk_valid SHALL rise 3 edges after the first edge at which fifo_empty=0 is sampled in IDLE.
REQ-020 SEND: chunk_out SHALL equal shift register bits [CHUNK-1:0]. Beats go out least-significant chunk first.
REQ-021 A beat SHALL transfer on an edge with chunk_valid=1 and chunk_ready=1. chunk_out, chunk_valid and chunk_last SHALL hold stable while chunk_ready=0.
REQ-022 On a non-last transfer, shift the register right by CHUNK bits and increment the beat counter.
REQ-023 chunk_last SHALL be 1 exactly when the beat counter equals NBEATS-1.
REQ-024 On the last transfer: increment words_done; if fifo_empty=0 at that edge, set fifo_rd_en<=1, chunk_valid<=0 and go to WAIT; otherwise set chunk_valid<=0 and go to IDLE.
REQ-025 Back-to-back words SHALL therefore incur exactly 2 bubble cycles (WAIT, LOAD) between the last beat and the next first beat.
REQ-026 fifo_rd_en SHALL never be set on an edge where fifo_empty=1. The block is the FIFO's only reader.
REQ-027 chunk_ready while chunk_valid=0 SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, fifo_rd_en=0, chunk_valid=0, chunk_last=0, chunk_out=0, busy=0, words_done=0, beat counter=0, shift register=0.
REQ-029 Reset mid-word SHALL discard the partially sent word with no further beats. A FIFO read already committed is lost and is not re-requested.
REQ-030 After rst deasserts, the first action SHALL follow REQ-016 on the first rising edge.

Verification
REQ-031 Single word: FIFO holds 0x...0F_0E_..._01_00 (32-bit chunk i = i), chunk_ready=1 -> fifo_rd_en pulses 1 cycle; beats 0..15 appear on consecutive cycles starting 3 edges after empty drops; chunk_last only on beat 15 (value 15); words_done=1; busy then 0.
REQ-032 Back-to-back: 3 words queued, chunk_ready=1 -> 48 beats total, exactly 2 idle cycles between words, fifo_rd_en pulses 3 times, words_done=3, FIFO ends empty.
REQ-033 Backpressure: chunk_ready toggles 1,0,0,1,... -> no beat lost or duplicated; chunk_out/valid/last stable during ready=0; received sequence 0..15.
REQ-034 Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd_en stays 0, chunk_valid stays 0, busy=0.
REQ-035 Reset mid-word: assert rst after beat 5 -> outputs zero in the same cycle without waiting for a clock edge; after release, the next queued word streams from beat 0 and words_done restarts at 0.
REQ-036 Wrap: preload words_done=0xFFFF via forced state, transfer one word -> words_done=0x0000.
